// File: rtl/rx_symbol_demux.sv
// Receive symbol demultiplexer.
// Classifies the received byte stream into packet payload (STP/SDP ... END/EDB),
// COM-led ordered sets (SKP/FTS/IDL) and framing errors. Every output is
// registered, so the response to a sampled byte appears on the following edge.
//
// Handshake: there is no back-pressure. valid_in qualifies D_in as a data byte
// (1) or a control character (0) on every clock. data_valid marks D_out as a
// payload byte for exactly one cycle, and the downstream buffer must accept it.
module rx_symbol_demux #(
   parameter int MAX_LEN = 1024,
   parameter int LEN_W   = 11,
   parameter int OS_SYMS = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       D_in,
   input  logic             valid_in,
   output logic [7:0]       D_out,
   output logic             data_valid,
   output logic             pkt_start,
   output logic             pkt_type,
   output logic             pkt_end,
   output logic             pkt_abort,
   output logic [LEN_W-1:0] pkt_len,
   output logic             os_valid,
   output logic [1:0]       os_type,
   output logic             err
);

   localparam logic [7:0] C_STP = 8'hFB;
   localparam logic [7:0] C_SDP = 8'h5C;
   localparam logic [7:0] C_END = 8'hFD;
   localparam logic [7:0] C_EDB = 8'hFE;
   localparam logic [7:0] C_SKP = 8'h1C;
   localparam logic [7:0] C_IDL = 8'h7C;
   localparam logic [7:0] C_FTS = 8'h3C;
   localparam logic [7:0] C_COM = 8'hBC;

   localparam int OSC_W = $clog2(OS_SYMS + 1);

   typedef enum logic [1:0] {
      S_LINK    = 2'd0,
      S_PKT     = 2'd1,
      S_OSET    = 2'd2,
      S_DISCARD = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic [OSC_W-1:0]   os_cnt_q, os_cnt_d;
   logic [OSC_W-1:0]   os_next;
   logic [1:0]         os_cur_q, os_cur_d;
   logic [1:0]         os_code;

   logic [7:0]         d_out_q, d_out_d;
   logic               data_valid_q, data_valid_d;
   logic               pkt_start_q, pkt_start_d;
   logic               pkt_type_q, pkt_type_d;
   logic               pkt_end_q, pkt_end_d;
   logic               pkt_abort_q, pkt_abort_d;
   logic [LEN_W-1:0]   pkt_len_q, pkt_len_d;
   logic               os_valid_q, os_valid_d;
   logic [1:0]         os_type_q, os_type_d;
   logic               err_q, err_d;

   // Map an ordered-set body symbol to its os_type encoding; 00 means "not one".
   always_comb begin
      os_code = 2'b00;
      if (!valid_in) begin
         case (D_in)
            C_SKP:   os_code = 2'b01;
            C_FTS:   os_code = 2'b10;
            C_IDL:   os_code = 2'b11;
            default: os_code = 2'b00;
         endcase
      end
   end

   // Next-state and next-output decode for the framing state machine.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      os_cnt_d     = os_cnt_q;
      os_cur_d     = os_cur_q;
      os_next      = os_cnt_q + 1'b1;
      d_out_d      = d_out_q;
      data_valid_d = 1'b0;
      pkt_start_d  = 1'b0;
      pkt_type_d   = pkt_type_q;
      pkt_end_d    = 1'b0;
      pkt_abort_d  = 1'b0;
      pkt_len_d    = pkt_len_q;
      os_valid_d   = 1'b0;
      os_type_d    = os_type_q;
      err_d        = 1'b0;

      case (state_q)
         S_LINK: begin
            if (valid_in) begin
               err_d = 1'b1;
            end else begin
               case (D_in)
                  C_STP, C_SDP: begin
                     pkt_start_d = 1'b1;
                     pkt_type_d  = (D_in == C_SDP);
                     cnt_d       = '0;
                     state_d     = S_PKT;
                  end
                  C_COM: begin
                     os_cnt_d = '0;
                     state_d  = S_OSET;
                  end
                  C_SKP, C_IDL, C_FTS: ;
                  default: err_d = 1'b1;
               endcase
            end
         end

         S_PKT: begin
            if (valid_in) begin
               if (cnt_q == LEN_W'(MAX_LEN)) begin
                  // Oversized packet: drop the offending byte and swallow the rest.
                  err_d       = 1'b1;
                  pkt_abort_d = 1'b1;
                  pkt_len_d   = LEN_W'(MAX_LEN);
                  state_d     = S_DISCARD;
               end else begin
                  d_out_d      = D_in;
                  data_valid_d = 1'b1;
                  cnt_d        = cnt_q + 1'b1;
               end
            end else begin
               pkt_len_d = cnt_q;
               case (D_in)
                  C_END: begin
                     pkt_end_d = 1'b1;
                     state_d   = S_LINK;
                  end
                  C_EDB: begin
                     pkt_abort_d = 1'b1;
                     state_d     = S_LINK;
                  end
                  C_STP, C_SDP: begin
                     // Missing terminator: abort the old packet and open the new one.
                     err_d       = 1'b1;
                     pkt_abort_d = 1'b1;
                     pkt_start_d = 1'b1;
                     pkt_type_d  = (D_in == C_SDP);
                     cnt_d       = '0;
                  end
                  C_COM: begin
                     err_d       = 1'b1;
                     pkt_abort_d = 1'b1;
                     os_cnt_d    = '0;
                     state_d     = S_OSET;
                  end
                  default: begin
                     err_d       = 1'b1;
                     pkt_abort_d = 1'b1;
                     state_d     = S_LINK;
                  end
               endcase
            end
         end

         S_DISCARD: begin
            if (!valid_in) begin
               case (D_in)
                  C_END, C_EDB: state_d = S_LINK;
                  C_STP, C_SDP: begin
                     pkt_start_d = 1'b1;
                     pkt_type_d  = (D_in == C_SDP);
                     cnt_d       = '0;
                     state_d     = S_PKT;
                  end
                  C_COM: begin
                     os_cnt_d = '0;
                     state_d  = S_OSET;
                  end
                  default: ;
               endcase
            end
         end

         S_OSET: begin
            if (valid_in) begin
               err_d   = 1'b1;
               state_d = S_LINK;
            end else if (D_in == C_COM) begin
               // A fresh COM restarts the set rather than leaving it.
               err_d    = 1'b1;
               os_cnt_d = '0;
            end else if ((os_cnt_q == '0) ? (os_code != 2'b00) : (os_code == os_cur_q)) begin
               os_cur_d = os_code;
               os_cnt_d = os_next;
               if (os_next == OSC_W'(OS_SYMS)) begin
                  os_valid_d = 1'b1;
                  os_type_d  = os_code;
                  os_cnt_d   = '0;
                  state_d    = S_LINK;
               end
            end else begin
               err_d   = 1'b1;
               state_d = S_LINK;
            end
         end

         default: state_d = S_LINK;
      endcase
   end

   // State, counters and registered outputs; reset drops any packet in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_LINK;
         cnt_q        <= '0;
         os_cnt_q     <= '0;
         os_cur_q     <= 2'b00;
         d_out_q      <= 8'h00;
         data_valid_q <= 1'b0;
         pkt_start_q  <= 1'b0;
         pkt_type_q   <= 1'b0;
         pkt_end_q    <= 1'b0;
         pkt_abort_q  <= 1'b0;
         pkt_len_q    <= '0;
         os_valid_q   <= 1'b0;
         os_type_q    <= 2'b00;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         os_cnt_q     <= os_cnt_d;
         os_cur_q     <= os_cur_d;
         d_out_q      <= d_out_d;
         data_valid_q <= data_valid_d;
         pkt_start_q  <= pkt_start_d;
         pkt_type_q   <= pkt_type_d;
         pkt_end_q    <= pkt_end_d;
         pkt_abort_q  <= pkt_abort_d;
         pkt_len_q    <= pkt_len_d;
         os_valid_q   <= os_valid_d;
         os_type_q    <= os_type_d;
         err_q        <= err_d;
      end
   end

   assign D_out      = d_out_q;
   assign data_valid = data_valid_q;
   assign pkt_start  = pkt_start_q;
   assign pkt_type   = pkt_type_q;
   assign pkt_end    = pkt_end_q;
   assign pkt_abort  = pkt_abort_q;
   assign pkt_len    = pkt_len_q;
   assign os_valid   = os_valid_q;
   assign os_type    = os_type_q;
   assign err        = err_q;

endmodule

// File: tb/tb_rx_symbol_demux.sv
// Bench for rx_symbol_demux: directed framing scenarios followed by randomized
// segments, every cycle compared against a queue-based reference model.
module tb_rx_symbol_demux;

   localparam int MAX_LEN = 1024;
   localparam int LEN_W   = 11;
   localparam int OS_SYMS = 3;

   localparam logic [7:0] STP = 8'hFB;
   localparam logic [7:0] SDP = 8'h5C;
   localparam logic [7:0] ENDC = 8'hFD;
   localparam logic [7:0] EDB = 8'hFE;
   localparam logic [7:0] SKP = 8'h1C;
   localparam logic [7:0] IDL = 8'h7C;
   localparam logic [7:0] FTS = 8'h3C;
   localparam logic [7:0] COM = 8'hBC;

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             reset;
   logic [7:0]       D_in;
   logic             valid_in;
   logic [7:0]       D_out;
   logic             data_valid, pkt_start, pkt_type, pkt_end, pkt_abort;
   logic [LEN_W-1:0] pkt_len;
   logic             os_valid;
   logic [1:0]       os_type;
   logic             err;

   always #5 clk = ~clk;

   rx_symbol_demux #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .OS_SYMS(OS_SYMS)) dut (
      .clk(clk), .reset(reset), .D_in(D_in), .valid_in(valid_in),
      .D_out(D_out), .data_valid(data_valid), .pkt_start(pkt_start),
      .pkt_type(pkt_type), .pkt_end(pkt_end), .pkt_abort(pkt_abort),
      .pkt_len(pkt_len), .os_valid(os_valid), .os_type(os_type), .err(err)
   );

   int total = 0;
   int bad   = 0;
   int dv_cnt = 0;

   // ---------------- reference model ----------------
   // Tracks the link as "inside a packet / inside an ordered set / discarding",
   // with the received payload and ordered-set symbols kept as queues.
   logic [7:0] payload[$];
   logic [7:0] os_syms[$];
   bit in_pkt, in_os, discarding;

   logic [7:0]       e_dout;
   logic             e_dv, e_start, e_type, e_end, e_abort, e_osv, e_err;
   logic [LEN_W-1:0] e_len;
   logic [1:0]       e_ostype;

   function automatic logic [1:0] os_enc(input logic [7:0] c);
      if (c == SKP) return 2'b01;
      if (c == FTS) return 2'b10;
      if (c == IDL) return 2'b11;
      return 2'b00;
   endfunction

   task automatic model_reset();
      payload.delete(); os_syms.delete();
      in_pkt = 0; in_os = 0; discarding = 0;
      e_dout = 0; e_dv = 0; e_start = 0; e_type = 0; e_end = 0; e_abort = 0;
      e_len = 0; e_osv = 0; e_ostype = 0; e_err = 0;
   endtask

   task automatic open_pkt(input logic [7:0] d);
      e_start = 1; e_type = (d == SDP); in_pkt = 1; payload.delete();
   endtask

   task automatic open_os();
      in_os = 1; os_syms.delete();
   endtask

   task automatic model_step(input logic vin, input logic [7:0] d);
      e_dv = 0; e_start = 0; e_end = 0; e_abort = 0; e_osv = 0; e_err = 0;
      if (in_pkt) begin
         if (vin) begin
            if (payload.size() == MAX_LEN) begin
               e_err = 1; e_abort = 1; e_len = LEN_W'(MAX_LEN);
               in_pkt = 0; discarding = 1;
            end else begin
               payload.push_back(d); e_dv = 1; e_dout = d;
            end
         end else begin
            e_len = LEN_W'(payload.size());
            in_pkt = 0;
            if (d == ENDC) e_end = 1;
            else if (d == EDB) e_abort = 1;
            else begin
               e_err = 1; e_abort = 1;
               if (d == STP || d == SDP) open_pkt(d);
               else if (d == COM) open_os();
            end
         end
      end else if (discarding) begin
         if (!vin) begin
            if (d == ENDC || d == EDB) discarding = 0;
            else if (d == STP || d == SDP) begin discarding = 0; open_pkt(d); end
            else if (d == COM) begin discarding = 0; open_os(); end
         end
      end else if (in_os) begin
         if (vin) begin
            e_err = 1; in_os = 0;
         end else if (d == COM) begin
            e_err = 1; os_syms.delete();
         end else if ((os_syms.size() == 0 && os_enc(d) != 2'b00) ||
                      (os_syms.size() != 0 && d == os_syms[0])) begin
            os_syms.push_back(d);
            if (os_syms.size() == OS_SYMS) begin
               e_osv = 1; e_ostype = os_enc(d); in_os = 0;
            end
         end else begin
            e_err = 1; in_os = 0;
         end
      end else begin
         if (vin) e_err = 1;
         else if (d == STP || d == SDP) open_pkt(d);
         else if (d == COM) open_os();
         else if (os_enc(d) == 2'b00) e_err = 1;
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string where);
      chk({where, ":D_out"},      32'(D_out),      32'(e_dout));
      chk({where, ":data_valid"}, 32'(data_valid), 32'(e_dv));
      chk({where, ":pkt_start"},  32'(pkt_start),  32'(e_start));
      chk({where, ":pkt_type"},   32'(pkt_type),   32'(e_type));
      chk({where, ":pkt_end"},    32'(pkt_end),    32'(e_end));
      chk({where, ":pkt_abort"},  32'(pkt_abort),  32'(e_abort));
      chk({where, ":pkt_len"},    32'(pkt_len),    32'(e_len));
      chk({where, ":os_valid"},   32'(os_valid),   32'(e_osv));
      chk({where, ":os_type"},    32'(os_type),    32'(e_ostype));
      chk({where, ":err"},        32'(err),        32'(e_err));
   endtask

   // ---------------- driver ----------------
   task automatic send(input logic vin, input logic [7:0] d, input string where);
      valid_in = vin;
      D_in     = d;
      @(posedge clk);
      #1;
      model_step(vin, d);
      if (data_valid) dv_cnt++;
      check_all(where);
   endtask

   task automatic ctl(input logic [7:0] d, input string where);
      send(1'b0, d, where);
   endtask

   task automatic dat(input logic [7:0] d, input string where);
      send(1'b1, d, where);
   endtask

   logic [7:0] ctl_tab[9];

   initial begin
      ctl_tab[0] = STP; ctl_tab[1] = SDP; ctl_tab[2] = ENDC; ctl_tab[3] = EDB;
      ctl_tab[4] = SKP; ctl_tab[5] = IDL; ctl_tab[6] = FTS; ctl_tab[7] = COM;
      ctl_tab[8] = 8'h00;

      // reset state
      reset = 1'b1; valid_in = 1'b0; D_in = 8'h00;
      #2;
      model_reset();
      check_all("reset");
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;

      // 1: STP 11 22 33 END
      ctl(STP, "t1"); dat(8'h11, "t1"); dat(8'h22, "t1"); dat(8'h33, "t1"); ctl(ENDC, "t1");
      // 2: SDP AA EDB
      ctl(SDP, "t2"); dat(8'hAA, "t2"); ctl(EDB, "t2");
      // 3: complete SKP set, then a mismatched FTS/IDL set
      ctl(COM, "t3"); ctl(SKP, "t3"); ctl(SKP, "t3"); ctl(SKP, "t3");
      ctl(COM, "t3b"); ctl(FTS, "t3b"); ctl(IDL, "t3b");
      dat(8'h55, "t3c");                      // confirms back in LINK: err
      // empty packet and an IDL ordered set
      ctl(STP, "t3d"); ctl(ENDC, "t3d");
      ctl(COM, "t3e"); ctl(IDL, "t3e"); ctl(IDL, "t3e"); ctl(IDL, "t3e");
      // COM restart inside a set
      ctl(COM, "t3f"); ctl(FTS, "t3f"); ctl(COM, "t3f");
      ctl(FTS, "t3f"); ctl(FTS, "t3f"); ctl(FTS, "t3f");

      // 4: overflow at byte MAX_LEN+1, then END returns silently
      dv_cnt = 0;
      ctl(STP, "t4");
      for (int i = 0; i < MAX_LEN + 1; i++) dat(8'($urandom_range(0, 255)), "t4");
      chk("t4:dv_count", 32'(dv_cnt), 32'(MAX_LEN));
      dat(8'h77, "t4"); ctl(ENDC, "t4");
      ctl(SDP, "t4b"); dat(8'h01, "t4b"); ctl(ENDC, "t4b");

      // 5: STP 01 STP -> abort+start same cycle; data in LINK
      ctl(STP, "t5"); dat(8'h01, "t5"); ctl(STP, "t5"); ctl(ENDC, "t5");
      dat(8'h99, "t5b");

      // 6: async reset mid-packet
      ctl(STP, "t6"); dat(8'h42, "t6"); dat(8'h43, "t6");
      #3 reset = 1'b1;
      #1;
      model_reset();
      check_all("t6:async");
      @(posedge clk); #1;
      check_all("t6:held");
      reset = 1'b0;
      dat(8'h10, "t6b"); ctl(STP, "t6b"); dat(8'h20, "t6b"); ctl(ENDC, "t6b");

      // randomized segments
      for (int s = 0; s < 400; s++) begin
         int kind;
         kind = $urandom_range(0, 3);
         if (kind == 0) begin
            int n;
            n = $urandom_range(0, 12);
            ctl(($urandom_range(0, 1) == 1) ? SDP : STP, "rnd_pkt");
            for (int i = 0; i < n; i++) dat(8'($urandom), "rnd_pkt");
            ctl(ctl_tab[($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : $urandom_range(2, 3)], "rnd_pkt");
         end else if (kind == 1) begin
            logic [7:0] sym;
            sym = ctl_tab[$urandom_range(4, 6)];
            ctl(COM, "rnd_os");
            for (int i = 0; i < OS_SYMS; i++)
               ctl(($urandom_range(0, 7) == 0) ? ctl_tab[$urandom_range(4, 7)] : sym, "rnd_os");
         end else begin
            for (int i = 0; i < 4; i++) begin
               if ($urandom_range(0, 2) == 0) dat(8'($urandom), "rnd_noise");
               else ctl(ctl_tab[$urandom_range(0, 8)], "rnd_noise");
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
